mmu_weight_loader: RTL and testbench

- Drives the weight-load interface on the top edge of the systolic MMU PE array: `global_w_wen`, per-column `w_wen`, per-column weight data, and `w_invalid`.
- Buffers one full weight tile from an upstream valid/ready stream, then shifts it into the PE columns as one contiguous burst.
- Mirrors each PE's active/shadow weight state so it never overwrites a shadow weight that has not yet been consumed.
- Sits between the weight SRAM reader and the PE array.

---
 rtl/mmu_weight_loader_if.sv | 30 +++
 rtl/mmu_weight_loader.sv | 146 ++++++++++++++
 tb/tb_mmu_weight_loader.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mmu_weight_loader_if.sv
// rtl/mmu_weight_loader_if.sv - weight stream, release handshake and PE-array write bus of the MMU weight loader
interface mmu_weight_loader_if #(
    parameter int DATA_WIDTH = 16,
    parameter int COLS       = 8
);
    logic                       wt_valid;
    logic                       wt_ready;
    logic [COLS*DATA_WIDTH-1:0] wt_data;
    logic                       release_valid;
    logic                       release_ready;
    logic                       global_w_wen;
    logic [COLS-1:0]            w_wen;
    logic [COLS*DATA_WIDTH-1:0] w_data;
    logic                       w_invalid;
    logic                       active_valid;
    logic                       shadow_valid;
    logic                       busy;

    modport master (
        output wt_valid, wt_data, release_valid,
        input  wt_ready, release_ready, global_w_wen, w_wen, w_data,
               w_invalid, active_valid, shadow_valid, busy
    );

    modport slave (
        input  wt_valid, wt_data, release_valid,
        output wt_ready, release_ready, global_w_wen, w_wen, w_data,
               w_invalid, active_valid, shadow_valid, busy
    );
endinterface

// File: rtl/mmu_weight_loader.sv
// rtl/mmu_weight_loader.sv - buffers one weight tile and bursts it into the PE array; MMU_WEIGHT_LOADER_PERF_EN adds perf counters
module mmu_weight_loader #(
    parameter int DATA_WIDTH = 16,
    parameter int ROWS       = 8,
    parameter int COLS       = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    mmu_weight_loader_if.slave    bus
`ifdef MMU_WEIGHT_LOADER_PERF_EN
    ,
    output logic [31:0]           perf_tiles,
    output logic [31:0]           perf_fill_stall,
    output logic [31:0]           perf_shadow_block
`endif
);
    localparam int CW = $clog2(ROWS + 1);
    localparam int IW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [CW-1:0] ROWS_C = CW'(ROWS);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_FILL   = 2'd1;
    localparam logic [1:0] S_STREAM = 2'd2;
    localparam logic [1:0] S_SETTLE = 2'd3;

    logic [1:0]                 state;
    logic [CW-1:0]              beat_cnt;
    logic [CW-1:0]              str_cnt;
    logic [COLS*DATA_WIDTH-1:0] buffer [ROWS];
    logic                       active_valid;
    logic                       shadow_valid;
    logic                       global_w_wen;
    logic [COLS-1:0]            w_wen;
    logic [COLS*DATA_WIDTH-1:0] w_data;
    logic                       w_invalid;
    logic                       wt_ready;
    logic                       release_ready;
    logic                       wt_fire;
    logic                       rel_fire;

    // A pending shadow tile blocks new data so it is never overwritten before release.
    assign wt_ready      = (state == S_IDLE || state == S_FILL) && !shadow_valid && (beat_cnt < ROWS_C);
    assign release_ready = (state == S_IDLE);
    assign wt_fire       = bus.wt_valid && wt_ready;
    assign rel_fire      = bus.release_valid && release_ready;

    assign bus.wt_ready      = wt_ready;
    assign bus.release_ready = release_ready;
    assign bus.global_w_wen  = global_w_wen;
    assign bus.w_wen         = w_wen;
    assign bus.w_data        = w_data;
    assign bus.w_invalid     = w_invalid;
    assign bus.active_valid  = active_valid;
    assign bus.shadow_valid  = shadow_valid;
    assign bus.busy          = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (wt_fire) begin
            buffer[beat_cnt[IW-1:0]] <= bus.wt_data;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= S_IDLE;
            beat_cnt     <= '0;
            str_cnt      <= '0;
            global_w_wen <= 1'b0;
            w_wen        <= '0;
            w_data       <= '0;
            w_invalid    <= 1'b0;
            active_valid <= 1'b0;
            shadow_valid <= 1'b0;
        end else begin
            w_invalid <= rel_fire;
            if (wt_fire) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
            if (rel_fire) begin
                if (shadow_valid) begin
                    shadow_valid <= 1'b0;
                end else begin
                    active_valid <= 1'b0;
                end
            end
            case (state)
                S_IDLE: begin
                    if (wt_fire) begin
                        state <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (beat_cnt == ROWS_C) begin
                        state        <= S_STREAM;
                        global_w_wen <= 1'b1;
                        w_wen        <= '1;
                        w_data       <= buffer[0];
                        str_cnt      <= CW'(1);
                    end
                end
                S_STREAM: begin
                    // Registered outputs lag the counter by one, so str_cnt==ROWS marks the last cycle.
                    if (str_cnt == ROWS_C) begin
                        state        <= S_SETTLE;
                        global_w_wen <= 1'b0;
                        w_wen        <= '0;
                        w_data       <= '0;
                    end else begin
                        w_data  <= buffer[str_cnt[IW-1:0]];
                        str_cnt <= str_cnt + 1'b1;
                    end
                end
                default: begin
                    if (!active_valid) begin
                        active_valid <= 1'b1;
                    end else begin
                        shadow_valid <= 1'b1;
                    end
                    beat_cnt <= '0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

`ifdef MMU_WEIGHT_LOADER_PERF_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            perf_tiles        <= '0;
            perf_fill_stall   <= '0;
            perf_shadow_block <= '0;
        end else begin
            if (state == S_STREAM && str_cnt == ROWS_C) begin
                perf_tiles <= perf_tiles + 32'd1;
            end
            // Only cycles actually waiting on upstream data count as stalls.
            if (state == S_FILL && !bus.wt_valid && beat_cnt < ROWS_C) begin
                perf_fill_stall <= perf_fill_stall + 32'd1;
            end
            if (bus.wt_valid && shadow_valid) begin
                perf_shadow_block <= perf_shadow_block + 32'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_mmu_weight_loader.sv
// tb/tb_mmu_weight_loader.sv - self-checking bench for mmu_weight_loader with a PE-array and tile-occupancy model
module tb_mmu_weight_loader;
    localparam int DW   = 16;
    localparam int ROWS = 4;
    localparam int COLS = 2;
    localparam int VW   = DW * COLS;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    mmu_weight_loader_if #(.DATA_WIDTH(DW), .COLS(COLS)) bus ();

`ifdef MMU_WEIGHT_LOADER_PERF_EN
    logic [31:0] perf_tiles, perf_fill_stall, perf_shadow_block;
`endif

    mmu_weight_loader #(.DATA_WIDTH(DW), .ROWS(ROWS), .COLS(COLS)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
`ifdef MMU_WEIGHT_LOADER_PERF_EN
        ,
        .perf_tiles        (perf_tiles),
        .perf_fill_stall   (perf_fill_stall),
        .perf_shadow_block (perf_shadow_block)
`endif
    );

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // PE array model driven by the loader outputs: shadow chain shifts down from row 0.
    logic [VW-1:0] pe_sh  [ROWS];
    logic [VW-1:0] pe_act [ROWS];
    logic          pe_act_v   = 1'b0;
    logic          pe_sh_pend = 1'b0;
    logic          prev_gw    = 1'b0;
    logic [VW-1:0] seen_q [$];
    int cur_run = 0, last_run = 0, inval_pulses = 0, inval_in_busy = 0, bad_wen = 0, bad_idle = 0;

    always @(negedge clk) begin
        if (!rstn) begin
            pe_act_v   = 1'b0;
            pe_sh_pend = 1'b0;
            prev_gw    = 1'b0;
            cur_run    = 0;
        end else begin
            if (bus.global_w_wen) begin
                if (bus.w_wen != '1) bad_wen++;
                for (int r = ROWS - 1; r > 0; r--) pe_sh[r] = pe_sh[r-1];
                pe_sh[0] = bus.w_data;
                seen_q.push_back(bus.w_data);
                cur_run++;
            end else if (bus.w_wen != '0 || bus.w_data != '0) begin
                bad_idle++;
            end
            if (prev_gw && !bus.global_w_wen) begin
                last_run = cur_run;
                cur_run  = 0;
                if (!pe_act_v) begin
                    pe_act   = pe_sh;
                    pe_act_v = 1'b1;
                end else begin
                    pe_sh_pend = 1'b1;
                end
            end
            if (bus.w_invalid) begin
                inval_pulses++;
                if (bus.global_w_wen || prev_gw) inval_in_busy++;
                if (pe_sh_pend) begin
                    pe_act     = pe_sh;
                    pe_sh_pend = 1'b0;
                end else begin
                    pe_act_v = 1'b0;
                end
            end
            prev_gw = bus.global_w_wen;
        end
    end

    // Reference: tiles held in the array (0..2), expected stream order, expected PE contents.
    logic [VW-1:0] tile    [ROWS];
    logic [VW-1:0] exp_act [ROWS];
    logic [VW-1:0] exp_sh  [ROWS];
    logic [VW-1:0] exp_q   [$];
    int held = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_tile();
        for (int i = 0; i < ROWS; i++) tile[i] = VW'($urandom);
    endtask

    task automatic send_beat(input logic [VW-1:0] d);
        int n = 0;
        bus.wt_valid = 1'b1;
        bus.wt_data  = d;
        while (!bus.wt_ready && n < 50) begin
            tick();
            n++;
        end
        check("beat_ready", bus.wt_ready, 1'b1);
        tick();
        bus.wt_valid = 1'b0;
        exp_q.push_back(d);
    endtask

    task automatic push_tile(input int first, input int gap_at, input int gap_len);
        for (int i = first; i < ROWS; i++) begin
            send_beat(tile[i]);
            if (i == gap_at) repeat (gap_len) tick();
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.busy && n < 100) begin
            tick();
            n++;
        end
        check("idle_reached", bus.busy, 1'b0);
    endtask

    task automatic tile_done_model();
        for (int r = 0; r < ROWS; r++) begin
            if (held == 0) exp_act[r] = tile[ROWS-1-r];
            else           exp_sh[r]  = tile[ROWS-1-r];
        end
        held = (held == 0) ? 1 : 2;
    endtask

    task automatic release_model();
        if (held == 2) begin
            exp_act = exp_sh;
            held    = 1;
        end else begin
            held = 0;
        end
    endtask

    task automatic check_stream(input string tag);
        check({tag, "_stream_len"}, seen_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < seen_q.size(); i++)
            check($sformatf("%s_stream_%0d", tag, i), seen_q[i], exp_q[i]);
        check({tag, "_burst_len"}, last_run, ROWS);
        seen_q.delete();
        exp_q.delete();
    endtask

    task automatic check_state(input string tag);
        check({tag, "_active_valid"}, bus.active_valid, held >= 1);
        check({tag, "_shadow_valid"}, bus.shadow_valid, held == 2);
        check({tag, "_pe_active_v"}, pe_act_v, held >= 1);
        if (held >= 1)
            for (int r = 0; r < ROWS; r++)
                check($sformatf("%s_pe_row%0d", tag, r), pe_act[r], exp_act[r]);
    endtask

    initial begin
        int n;
        int rr_busy;
        int inval_before;
        bus.wt_valid      = 1'b0;
        bus.wt_data       = '0;
        bus.release_valid = 1'b0;

        // Reset state
        repeat (2) tick();
        check("rst_wt_ready", bus.wt_ready, 1'b1);
        check("rst_release_ready", bus.release_ready, 1'b1);
        check("rst_gw", bus.global_w_wen, 1'b0);
        check("rst_w_wen", bus.w_wen, '0);
        check("rst_w_data", bus.w_data, '0);
        check("rst_w_invalid", bus.w_invalid, 1'b0);
        check("rst_active", bus.active_valid, 1'b0);
        check("rst_shadow", bus.shadow_valid, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        rstn = 1'b1;
        tick();

        // Tile A: fixed pattern, back-to-back
        for (int i = 0; i < ROWS; i++) tile[i] = {16'h0100 + 16'(ROWS - i), 16'(ROWS - i)};
        push_tile(0, -1, 0);
        wait_idle();
        tile_done_model();
        check_stream("tileA");
        check_state("tileA");
        check("tileA_row0_col1", pe_act[0][DW +: DW], 16'h0101);
        check("tileA_row3_col0", pe_act[3][0 +: DW], 16'h0004);

        // Tile B: 5-cycle gap between beats 1 and 2, lands in shadow
        rand_tile();
        push_tile(0, 1, 5);
        wait_idle();
        tile_done_model();
        check_stream("tileB");
        check_state("tileB");
`ifdef MMU_WEIGHT_LOADER_PERF_EN
        check("perf_tiles", perf_tiles, 32'd2);
        check("perf_fill_stall", perf_fill_stall, 32'd5);
`endif
        bus.wt_valid = 1'b1;
        bus.wt_data  = VW'($urandom);
        for (int i = 0; i < 3; i++) begin
            check("shadow_blocks_ready", bus.wt_ready, 1'b0);
            tick();
        end
        bus.wt_valid = 1'b0;
`ifdef MMU_WEIGHT_LOADER_PERF_EN
        check("perf_shadow_block", perf_shadow_block, 32'd3);
`endif

        // Release promotes tile B
        inval_before = inval_pulses;
        bus.release_valid = 1'b1;
        check("rel_ready", bus.release_ready, 1'b1);
        tick();
        bus.release_valid = 1'b0;
        release_model();
        check("rel_w_invalid_hi", bus.w_invalid, 1'b1);
        tick();
        check("rel_w_invalid_lo", bus.w_invalid, 1'b0);
        check("rel_pulse_count", inval_pulses - inval_before, 1);
        check_state("relB");

        // Tile C with release held through FILL/STREAM/SETTLE
        rand_tile();
        push_tile(0, -1, 0);
        bus.release_valid = 1'b1;
        inval_before = inval_pulses;
        rr_busy = 0;
        n = 0;
        while (bus.busy && n < 100) begin
            if (bus.release_ready) rr_busy++;
            tick();
            n++;
        end
        check("held_rel_idle", bus.busy, 1'b0);
        check("held_rel_ready_busy", rr_busy, 0);
        check("held_rel_no_pulse", inval_pulses - inval_before, 0);
        tile_done_model();
        check_stream("tileC");
        check("held_rel_ready_idle", bus.release_ready, 1'b1);
        tick();
        bus.release_valid = 1'b0;
        release_model();
        check("held_rel_w_invalid", bus.w_invalid, 1'b1);
        tick();
        check("held_rel_pulse_count", inval_pulses - inval_before, 1);
        check_state("relC");

        // Tile D: release and first beat accepted together
        rand_tile();
        bus.release_valid = 1'b1;
        bus.wt_valid      = 1'b1;
        bus.wt_data       = tile[0];
        check("simul_wt_ready", bus.wt_ready, 1'b1);
        check("simul_rel_ready", bus.release_ready, 1'b1);
        tick();
        bus.release_valid = 1'b0;
        bus.wt_valid      = 1'b0;
        exp_q.push_back(tile[0]);
        release_model();
        check("simul_w_invalid", bus.w_invalid, 1'b1);
        check("simul_busy", bus.busy, 1'b1);
        check("simul_active", bus.active_valid, 1'b0);
        push_tile(1, -1, 0);
        wait_idle();
        tile_done_model();
        check_stream("tileD");
        check_state("tileD");

        // Tile E: reset in stream cycle 2
        rand_tile();
        push_tile(0, -1, 0);
        n = 0;
        while (!bus.global_w_wen && n < 20) begin
            tick();
            n++;
        end
        check("e_stream_start", bus.global_w_wen, 1'b1);
        tick();
        tick();
        check("e_stream_k2", bus.w_data, tile[2]);
        #2 rstn = 1'b0;
        #1;
        check("ar_gw", bus.global_w_wen, 1'b0);
        check("ar_w_wen", bus.w_wen, '0);
        check("ar_w_data", bus.w_data, '0);
        check("ar_w_invalid", bus.w_invalid, 1'b0);
        check("ar_active", bus.active_valid, 1'b0);
        check("ar_shadow", bus.shadow_valid, 1'b0);
        check("ar_busy", bus.busy, 1'b0);
        check("ar_wt_ready", bus.wt_ready, 1'b1);
        check("ar_release_ready", bus.release_ready, 1'b1);
`ifdef MMU_WEIGHT_LOADER_PERF_EN
        check("ar_perf_tiles", perf_tiles, 32'd0);
        check("ar_perf_fill_stall", perf_fill_stall, 32'd0);
        check("ar_perf_shadow_block", perf_shadow_block, 32'd0);
`endif
        held = 0;
        tick();
        tick();
        seen_q.delete();
        exp_q.delete();
        rstn = 1'b1;
        repeat (3) tick();
        check("post_rst_no_write", seen_q.size(), 0);

        // Tile F after reset: buffer order restarts at beat 0
        rand_tile();
        push_tile(0, 2, 2);
        wait_idle();
        tile_done_model();
        check_stream("tileF");
        check_state("tileF");

        check("wen_all_ones_in_stream", bad_wen, 0);
        check("outputs_zero_outside_stream", bad_idle, 0);
        check("no_invalid_in_stream_settle", inval_in_busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
